// File: rtl/corr_frame_sequencer.sv
// Frame sequencer for the squared-product MAC correlator: buffers a frame,
// streams coefficient/sample pairs, reports the accumulator delta per frame.
module corr_frame_sequencer #(
    parameter int TAPS    = 16,
    parameter int DATA_W  = 32,
    parameter int MAC_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [DATA_W-1:0]       coef_data,
    output logic                    coef_busy,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    output logic [DATA_W-1:0]       mac_a,
    output logic [DATA_W-1:0]       mac_b,
    input  logic [DATA_W-1:0]       mac_out,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [DATA_W-1:0]       r_data,
    output logic [15:0]             r_frame
);

    localparam int AW = $clog2(TAPS);
    localparam int WW = $clog2(MAC_LAT + 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]     fill_cnt;
    logic [AW-1:0]     tap_cnt;
    logic [WW-1:0]     wait_cnt;
    logic [DATA_W-1:0] baseline;

    logic [DATA_W-1:0] coef_mem [TAPS];
    logic [DATA_W-1:0] samp_mem [TAPS];

    logic fill_fire;
    logic fill_last;
    logic tap_last;
    logic wait_last;
    logic r_fire;
    logic coef_wr;

    always_comb begin
        state_d   = state_q;
        s_ready   = (state_q == S_FILL);
        coef_busy = (state_q == S_RUN) || (state_q == S_WAIT);
        fill_fire = s_valid && s_ready;
        fill_last = (fill_cnt == AW'(TAPS - 1));
        tap_last  = (tap_cnt == AW'(TAPS - 1));
        wait_last = (wait_cnt == WW'(MAC_LAT));
        r_fire    = r_valid && r_ready;
        coef_wr   = coef_we && !coef_busy;
        unique case (state_q)
            S_FILL: if (fill_fire && fill_last) state_d = S_RUN;
            S_RUN:  if (tap_last) state_d = S_WAIT;
            S_WAIT: if (wait_last) state_d = S_HOLD;
            S_HOLD: if (r_fire) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    // Storage only; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (coef_wr) coef_mem[coef_addr] <= coef_data;
        if (fill_fire) samp_mem[fill_cnt] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FILL;
            fill_cnt <= '0;
            tap_cnt  <= '0;
            wait_cnt <= '0;
            baseline <= '0;
            mac_a    <= '0;
            mac_b    <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_frame  <= '0;
        end else begin
            state_q <= state_d;
            if (fill_fire) begin
                fill_cnt <= fill_last ? '0 : fill_cnt + 1'b1;
                // Accumulator is idle here: zeros have been driven since HOLD.
                if (fill_last) baseline <= mac_out;
            end
            if (state_q == S_RUN) begin
                mac_a   <= coef_mem[tap_cnt];
                mac_b   <= samp_mem[tap_cnt];
                tap_cnt <= tap_last ? '0 : tap_cnt + 1'b1;
            end else begin
                mac_a <= '0;
                mac_b <= '0;
            end
            if (state_q == S_WAIT) begin
                wait_cnt <= wait_last ? '0 : wait_cnt + 1'b1;
                if (wait_last) begin
                    r_data  <= mac_out - baseline;
                    r_valid <= 1'b1;
                end
            end
            if (r_fire) begin
                r_valid <= 1'b0;
                r_frame <= r_frame + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_corr_frame_sequencer.sv
// Bench for corr_frame_sequencer with a behavioural correlator model
// and a result scoreboard.
module tb_corr_frame_sequencer;

    localparam int TAPS = 4;
    localparam int DW   = 32;
    localparam int ML   = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          coef_we;
    logic [1:0]    coef_addr;
    logic [DW-1:0] coef_data;
    logic          coef_busy;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic [DW-1:0] mac_out;
    logic          r_valid;
    logic          r_ready;
    logic [DW-1:0] r_data;
    logic [15:0]   r_frame;

    corr_frame_sequencer #(.TAPS(TAPS), .DATA_W(DW), .MAC_LAT(ML)) dut (
        .clk(clk), .rst(rst),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_busy(coef_busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .r_frame(r_frame)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Correlator term: product of a with b squared, then squared.
    function automatic logic [31:0] term(input logic [31:0] a,
                                         input logic [31:0] b);
        logic [31:0] p;
        p = a * b * b;
        return p * p;
    endfunction

    logic [31:0] acc;
    logic        preload = 1'b1;
    logic [31:0] preload_val = 32'd0;

    always @(posedge clk) begin
        if (preload) acc <= preload_val;
        else acc <= acc + term(mac_a, mac_b);
    end
    assign mac_out = acc;

    typedef struct {
        logic [31:0] data;
        logic [15:0] frame;
    } res_t;

    res_t        sb[$];
    logic [31:0] coef_m [TAPS];
    logic [15:0] frame_m = 16'd0;

    always @(negedge clk) begin
        if (r_valid && r_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                res_t e;
                e = sb.pop_front();
                check("r_data", r_data, e.data);
                check("r_frame", {16'd0, r_frame}, {16'd0, e.frame});
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input logic [31:0] d,
                              input bit update);
        coef_we   = 1'b1;
        coef_addr = addr[1:0];
        coef_data = d;
        cycle();
        coef_we = 1'b0;
        if (update) coef_m[addr] = d;
    endtask

    task automatic load_coef(input logic [31:0] c [TAPS]);
        for (int k = 0; k < TAPS; k++) write_coef(k, c[k], 1'b1);
    endtask

    task automatic send_samples(input logic [31:0] s [TAPS]);
        res_t        e;
        logic [31:0] sum;
        int          n;
        sum = 32'd0;
        for (int k = 0; k < TAPS; k++) sum += term(coef_m[k], s[k]);
        e.data  = sum;
        e.frame = frame_m;
        frame_m++;
        sb.push_back(e);
        for (int k = 0; k < TAPS; k++) begin
            s_valid = 1'b1;
            s_data  = s[k];
            n = 0;
            while (!s_ready && n < 200) begin
                cycle();
                n++;
            end
            if (!s_ready) check("s_ready_timeout", {31'd0, s_ready}, 32'd1);
            cycle();
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!r_valid && lat < 50) begin
            cycle();
            lat++;
        end
        if (!r_valid) check("r_valid_timeout", {31'd0, r_valid}, 32'd1);
    endtask

    int          lat;
    res_t        held;
    logic [31:0] mo;

    initial begin
        rst = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        s_valid = 1'b0; s_data = '0; r_ready = 1'b1;
        repeat (3) cycle();
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("rst_r_valid", {31'd0, r_valid}, 32'd0);
        check("rst_r_data", r_data, 32'd0);
        check("rst_r_frame", {16'd0, r_frame}, 32'd0);
        check("rst_mac_a", mac_a, 32'd0);
        check("rst_mac_b", mac_b, 32'd0);
        check("rst_coef_busy", {31'd0, coef_busy}, 32'd0);
        rst = 1'b0;
        preload = 1'b0;
        cycle();

        // Basic frame and latency
        load_coef('{1, 1, 1, 1});
        send_samples('{2, 2, 2, 2});
        wait_valid(lat);
        check("latency", lat, 32'd6);
        check("frame1_value", r_data, 32'd64);
        cycle();

        // Back-to-back frames, nonzero baseline
        load_coef('{1, 2, 3, 4});
        send_samples('{1, 1, 1, 1});
        wait_valid(lat);
        check("frame2_value", r_data, 32'd30);
        send_samples('{1, 1, 1, 1});
        wait_valid(lat);
        check("frame3_value", r_data, 32'd30);
        cycle();

        // Output backpressure
        r_ready = 1'b0;
        send_samples('{3, 1, 2, 1});
        wait_valid(lat);
        held = sb[0];
        mo = mac_out;
        for (int i = 0; i < 10; i++) begin
            check("hold_r_data", r_data, held.data);
            check("hold_s_ready", {31'd0, s_ready}, 32'd0);
            check("hold_mac_out", mac_out, mo);
            cycle();
        end
        r_ready = 1'b1;
        cycle();
        check("post_hold_s_ready", {31'd0, s_ready}, 32'd1);
        check("post_hold_r_valid", {31'd0, r_valid}, 32'd0);

        // Accumulator wrap
        load_coef('{1, 1, 1, 1});
        preload_val = 32'h7FFF_FFF0;
        preload = 1'b1;
        cycle();
        preload = 1'b0;
        send_samples('{2, 2, 2, 2});
        wait_valid(lat);
        check("wrap_value", r_data, 32'd64);
        check("wrap_crossed", {31'd0, mac_out[31]}, 32'd1);
        cycle();

        // Coefficient write blocked in RUN, accepted in HOLD
        r_ready = 1'b0;
        send_samples('{1, 1, 1, 1});
        check("run_coef_busy", {31'd0, coef_busy}, 32'd1);
        write_coef(0, 32'd9, 1'b0);
        wait_valid(lat);
        check("run_write_ignored", r_data, 32'd4);
        check("hold_coef_busy", {31'd0, coef_busy}, 32'd0);
        write_coef(0, 32'd9, 1'b1);
        r_ready = 1'b1;
        cycle();
        send_samples('{1, 1, 1, 1});
        wait_valid(lat);
        check("hold_write_used", r_data, 32'd84);
        cycle();

        // Reset in the middle of RUN
        send_samples('{2, 1, 1, 1});
        cycle();
        cycle();
        check("pre_rst_busy", {31'd0, coef_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_mac_a", mac_a, 32'd0);
        check("mid_rst_mac_b", mac_b, 32'd0);
        check("mid_rst_r_valid", {31'd0, r_valid}, 32'd0);
        check("mid_rst_s_ready", {31'd0, s_ready}, 32'd1);
        sb.delete();
        frame_m = 16'd0;
        cycle();
        rst = 1'b0;
        cycle();
        send_samples('{1, 2, 1, 2});
        wait_valid(lat);
        check("post_rst_latency", lat, 32'd6);
        repeat (4) cycle();
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
